// File: rtl/acia_pkg.sv
// acia_pkg: shared register map, status bit positions, default divider and FSM encodings for acia_uart
package acia_pkg;
  localparam int CLK_DIV_DEFAULT = 104;
  localparam logic REG_STAT = 1'b0;
  localparam logic REG_DATA = 1'b1;
  localparam int ST_RXF  = 0;
  localparam int ST_TXE  = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_FERR = 3;
  localparam int ST_IRQ  = 7;
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;
endpackage

// File: rtl/acia_uart_rx.sv
// uart_rx: 2-FF rx synchronizer and 8N1 receiver (i_rx in; o_valid 1-cycle strobe at stop sample, o_data byte, o_ferr stop bit low)
module uart_rx
  import acia_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_ferr
);
  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] C_LAST = W'(CLK_DIV - 1);
  localparam logic [W-1:0] C_HALF = W'(CLK_DIV / 2 - 1);
  logic [1:0]   r_sync;
  logic         r_prev;
  logic [1:0]   r_state;
  logic [W-1:0] r_cnt;
  logic [2:0]   r_bit;
  logic [7:0]   r_sh;
  logic         w_rx;
  assign w_rx = r_sync[1];
  assign o_data = r_sh;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      o_valid <= 1'b0;
      o_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_prev  <= w_rx;
      o_valid <= 1'b0;
      r_cnt   <= r_cnt + W'(1);
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (r_prev && !w_rx) r_state <= RX_START;
        end
        RX_START: if (r_cnt == C_HALF) begin
          r_cnt   <= '0;
          r_bit   <= '0;
          r_state <= w_rx ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (r_cnt == C_LAST) begin
          r_cnt   <= '0;
          r_sh    <= {w_rx, r_sh[7:1]};
          r_bit   <= r_bit + 3'd1;
          r_state <= (r_bit == 3'd7) ? RX_STOP : RX_DATA;
        end
        RX_STOP: if (r_cnt == C_LAST) begin
          r_cnt   <= '0;
          r_state <= RX_IDLE;
          o_valid <= 1'b1;
          o_ferr  <= !w_rx;
        end
      endcase
    end
  end
endmodule

// File: rtl/acia_uart.sv
// acia_uart: memory-mapped 8N1 UART (cs/we/rs/din bus in, registered dout, rx in, tx out, level irq out)
module acia_uart
  import acia_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic       rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);
  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] C_LAST = W'(CLK_DIV - 1);
  logic         r_rxf, r_txe, r_ovr, r_ferr, r_rxie, r_txie, r_irq;
  logic [7:0]   r_rx_data, r_hold, r_tx_sh, r_dout, w_status;
  logic [1:0]   r_tx_state;
  logic [W-1:0] r_tx_cnt;
  logic [2:0]   r_tx_bit;
  logic         w_rd, w_rd_data, w_wr_ctrl, w_wr_data;
  logic         w_tx_end, w_tx_load, w_tx_accept;
  logic         w_rx_valid, w_rx_ferr;
  logic [7:0]   w_rx_data;
  uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk    (clk),
    .rst    (rst),
    .i_rx   (rx),
    .o_valid(w_rx_valid),
    .o_data (w_rx_data),
    .o_ferr (w_rx_ferr)
  );
  assign w_rd        = cs && !we;
  assign w_rd_data   = w_rd && rs == REG_DATA;
  assign w_wr_ctrl   = cs && we && rs == REG_STAT;
  assign w_wr_data   = cs && we && rs == REG_DATA;
  assign w_tx_end    = r_tx_cnt == C_LAST;
  assign w_tx_load   = !r_txe && (r_tx_state == TX_IDLE || (r_tx_state == TX_STOP && w_tx_end));
  assign w_tx_accept = w_wr_data && (r_txe || w_tx_load);
  assign dout        = r_dout;
  assign irq         = r_irq;
  always_comb begin
    w_status          = '0;
    w_status[ST_RXF]  = r_rxf;
    w_status[ST_TXE]  = r_txe;
    w_status[ST_OVR]  = r_ovr;
    w_status[ST_FERR] = r_ferr;
    w_status[ST_IRQ]  = r_irq;
    tx = (r_tx_state == TX_START) ? 1'b0 : (r_tx_state == TX_DATA) ? r_tx_sh[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxf     <= 1'b0;
      r_ovr     <= 1'b0;
      r_ferr    <= 1'b0;
      r_rxie    <= 1'b0;
      r_txie    <= 1'b0;
      r_irq     <= 1'b0;
      r_rx_data <= '0;
      r_dout    <= '0;
    end else begin
      if (w_rd) r_dout <= rs ? r_rx_data : w_status;
      if (w_wr_ctrl) {r_txie, r_rxie} <= din[1:0];
      r_irq <= (r_rxie && r_rxf) || (r_txie && r_txe);
      if (w_rx_valid && (!r_rxf || w_rd_data)) begin
        r_rx_data <= w_rx_data;
        r_rxf     <= 1'b1;
        r_ferr    <= w_rx_ferr;
        r_ovr     <= 1'b0;
      end else if (w_rx_valid) begin
        r_ovr <= 1'b1;
      end else if (w_rd_data) begin
        r_rxf  <= 1'b0;
        r_ovr  <= 1'b0;
        r_ferr <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txe      <= 1'b1;
      r_hold     <= '0;
      r_tx_sh    <= '0;
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
    end else begin
      if (w_tx_accept) r_hold <= din;
      r_txe    <= w_tx_accept ? 1'b0 : w_tx_load ? 1'b1 : r_txe;
      r_tx_cnt <= (r_tx_state == TX_IDLE || w_tx_end) ? '0 : r_tx_cnt + W'(1);
      if (w_tx_load) begin
        r_tx_sh    <= r_hold;
        r_tx_state <= TX_START;
      end else if (w_tx_end) begin
        r_tx_state <= (r_tx_state == TX_START) ? TX_DATA :
                      (r_tx_state == TX_DATA && r_tx_bit != 3'd7) ? TX_DATA :
                      (r_tx_state == TX_DATA) ? TX_STOP : TX_IDLE;
        r_tx_bit   <= (r_tx_state == TX_DATA) ? r_tx_bit + 3'd1 : 3'd0;
        if (r_tx_state == TX_DATA) r_tx_sh <= r_tx_sh >> 1;
      end
    end
  end
endmodule

// File: tb/tb_acia_uart.sv
// tb_acia_uart: randomized self-checking bench for acia_uart against an event-level register model and a tx frame decoder
module tb_acia_uart;
  localparam int DIV = 8;
  localparam int FB = 10 * DIV;
  logic clk = 0, rst = 1, cs = 0, we = 0, rs = 0, rx = 1;
  logic [7:0] din = 0;
  logic [7:0] dout;
  logic tx, irq;
  acia_uart #(.CLK_DIV(DIV)) dut (
    .clk (clk), .rst(rst), .cs(cs), .we(we), .rs(rs), .din(din),
    .dout(dout), .rx(rx), .tx(tx), .irq(irq)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       wide_ok;
    int         t0;
  } frame_t;
  frame_t mon_q[$];
  initial begin : tx_mon
    logic s[FB];
    frame_t f;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        f.t0 = cyc;
        s[0] = tx;
        for (int k = 1; k < FB; k++) begin
          @(negedge clk);
          s[k] = tx;
        end
        f.wide_ok = 1'b1;
        for (int k = 0; k < FB; k++) if (s[k] !== s[k - k % DIV]) f.wide_ok = 1'b0;
        for (int b = 0; b < 8; b++) f.data[b] = s[(b + 1) * DIV];
        f.stop = s[9 * DIV];
        mon_q.push_back(f);
      end
    end
  end
  logic m_rxf, m_ovr, m_ferr, m_rxie, m_txie;
  logic [7:0] m_data;
  function automatic logic [7:0] m_status();
    logic m_irq;
    m_irq = (m_rxie & m_rxf) | m_txie;
    return {m_irq, 3'b000, m_ferr, m_ovr, 1'b1, m_rxf};
  endfunction
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic r, input logic [7:0] d);
    cs = 1; we = 1; rs = r; din = d;
    @(negedge clk);
    cs = 0; we = 0;
  endtask
  task automatic rd(input logic r, output logic [7:0] v);
    cs = 1; we = 0; rs = r;
    @(negedge clk);
    v = dout;
    cs = 0;
  endtask
  task automatic model_reset();
    m_rxf = 0; m_ovr = 0; m_ferr = 0; m_rxie = 0; m_txie = 0; m_data = 0;
  endtask
  task automatic do_reset();
    rst = 1; cs = 0; we = 0; rx = 1;
    idle(3);
    rst = 0;
    model_reset();
    idle(1);
  endtask
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      idle(DIV);
    end
    rx = 1;
    if (!m_rxf) begin
      m_data = b; m_rxf = 1; m_ferr = !stop;
    end else m_ovr = 1;
    idle(2);
  endtask
  task automatic check_stat(input string tag);
    logic [7:0] v;
    rd(0, v);
    chk(tag, v, m_status());
  endtask
  task automatic check_data(input string tag);
    logic [7:0] v;
    rd(1, v);
    chk(tag, v, m_data);
    m_rxf = 0; m_ovr = 0; m_ferr = 0;
    idle(1);
  endtask
  task automatic wait_frames(input string tag, input int n);
    int t;
    t = 0;
    while (mon_q.size() < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, mon_q.size(), n);
  endtask
  task automatic chk_frame(input string tag, input logic [7:0] b, output int t0);
    frame_t f;
    t0 = 0;
    chk({tag, "_present"}, 32'(mon_q.size() > 0), 1);
    if (mon_q.size() == 0) return;
    f = mon_q.pop_front();
    t0 = f.t0;
    chk({tag, "_data"}, f.data, b);
    chk({tag, "_stop"}, f.stop, 1);
    chk({tag, "_width"}, f.wide_ok, 1);
  endtask
  initial begin
    logic [7:0] v, c;
    int tw, t1, t2;
    do_reset();
    chk("rst_dout", dout, 0);
    chk("rst_tx", tx, 1);
    chk("rst_irq", irq, 0);
    rd(0, v);
    chk("rst_stat", v, 8'h02);
    tw = cyc;
    wr(1, 8'hA5);
    rd(0, v);
    chk("txe_low", v, 8'h00);
    rd(0, v);
    chk("txe_back", v, 8'h02);
    wait_frames("a5_wait", 1);
    chk_frame("a5", 8'hA5, t1);
    chk("a5_start", t1, tw + 2);
    idle(4);
    tw = cyc;
    wr(1, 8'h11);
    wr(1, 8'h22);
    wr(1, 8'h33);
    wait_frames("b2b_wait", 2);
    chk_frame("b2b_1", 8'h11, t1);
    chk_frame("b2b_2", 8'h22, t2);
    chk("b2b_start", t1, tw + 2);
    chk("b2b_gap", t2, t1 + FB);
    idle(120);
    chk("drop_third", mon_q.size(), 0);
    rx_frame(8'h3C, 1);
    check_stat("rx_stat");
    check_data("rx_data");
    check_stat("rx_stat_clr");
    rx = 0;
    idle(4);
    rx = 1;
    idle(20);
    check_stat("glitch_stat");
    rx_frame(8'h11, 1);
    rx_frame(8'h22, 1);
    check_stat("ovr_stat");
    check_data("ovr_data");
    check_stat("ovr_clr");
    rx_frame(8'h5A, 0);
    check_stat("ferr_stat");
    check_data("ferr_data");
    wr(0, 8'h01);
    m_rxie = 1;
    idle(1);
    chk("irq_idle", irq, 0);
    rx_frame(8'h77, 1);
    chk("irq_rx", irq, 1);
    rd(1, v);
    chk("irq_data", v, 8'h77);
    m_rxf = 0;
    chk("irq_hold", irq, 1);
    idle(1);
    chk("irq_clr", irq, 0);
    wr(0, 8'h03);
    m_txie = 1;
    idle(1);
    chk("irq_tx", irq, 1);
    check_stat("irq_stat");
    wr(1, 8'hC3);
    idle(30);
    rst = 1;
    #1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_dout", dout, 0);
    chk("rst_mid_irq", irq, 0);
    idle(2);
    rst = 0;
    model_reset();
    idle(1);
    rd(0, v);
    chk("rst_mid_stat", v, 8'h02);
    idle(100);
    mon_q.delete();
    rx_frame(8'($urandom), 1);
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          rx_frame(8'($urandom), $urandom_range(0, 3) != 0);
          idle($urandom_range(0, 3));
        end
        1: check_data("rnd_data");
        2: check_stat("rnd_stat");
        3: begin
          c = 8'($urandom);
          wr(0, c);
          m_rxie = c[0];
          m_txie = c[1];
          idle(1);
        end
        default: begin
          c = 8'($urandom);
          wr(1, c);
          wait_frames("rnd_tx_wait", 1);
          chk_frame("rnd_tx", c, t1);
        end
      endcase
      chk("rnd_irq", irq, (m_rxie & m_rxf) | m_txie);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
